// File: rtl/pc_redirect_unit_if.sv
// Bundle between the front-end PC owner and its neighbours.
//   jump_writer (from execute/commit): jw_do_jump, jw_jump_inst, jw_dest_addr, jw_inst_counter
//   ibus: ireq_valid/ireq_addr (request), iresp_valid/iresp_data (data_ok pulse + instruction)
//   decode: out_valid/out_ready handshake with out_pc, out_inst, out_counter
//   status: flush, misalign_err, jump_cnt, redirect_cnt
// modport master is the fetch unit side; modport slave is the environment side.
interface pc_redirect_unit_if #(
  parameter int unsigned CNT_W = 64
);
  logic             jw_do_jump;
  logic             jw_jump_inst;
  logic [63:0]      jw_dest_addr;
  logic [CNT_W-1:0] jw_inst_counter;
  logic             ireq_valid;
  logic [63:0]      ireq_addr;
  logic             iresp_valid;
  logic [31:0]      iresp_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_inst;
  logic [CNT_W-1:0] out_counter;
  logic             flush;
  logic             misalign_err;
  logic [CNT_W-1:0] jump_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  jw_do_jump, jw_jump_inst, jw_dest_addr, jw_inst_counter,
    input  iresp_valid, iresp_data, out_ready,
    output ireq_valid, ireq_addr, out_valid, out_pc, out_inst, out_counter,
    output flush, misalign_err, jump_cnt, redirect_cnt
  );

  modport slave (
    output jw_do_jump, jw_jump_inst, jw_dest_addr, jw_inst_counter,
    output iresp_valid, iresp_data, out_ready,
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_inst, out_counter,
    input  flush, misalign_err, jump_cnt, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: front-end PC owner and single-outstanding instruction fetcher.
// Issues one ibus request at a time, hands each fetched instruction to decode with
// its PC and sequence number, and applies jump_writer redirects with a one-cycle
// flush, discarding any in-flight or held wrong-path instruction.
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    pc_redirect_unit_if.master (jump_writer in, ibus req/resp, decode out, status)
module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned CNT_W    = 64
) (
  input logic                clk,
  input logic                reset,
  pc_redirect_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t           state, state_nx;
  logic [63:0]      pc, pc_nx;
  logic [63:0]      pending_pc, pending_nx;
  logic [63:0]      target;
  logic [CNT_W-1:0] seq, seq_nx;
  logic             latch;
  logic [63:0]      out_pc_q;
  logic [31:0]      out_inst_q;
  logic [CNT_W-1:0] out_counter_q;
  logic             misalign_q;
  logic [CNT_W-1:0] jump_cnt_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  assign target = {bus.jw_dest_addr[63:2], 2'b00};

  assign bus.ireq_valid   = (state == FETCH);
  assign bus.ireq_addr    = pc;
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_pc       = out_pc_q;
  assign bus.out_inst     = out_inst_q;
  assign bus.out_counter  = out_counter_q;
  assign bus.flush        = bus.jw_do_jump;
  assign bus.misalign_err = misalign_q;
  assign bus.jump_cnt     = jump_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;

  // A redirect overrides every other event in the cycle. While a request is
  // outstanding the target is parked in pending_pc so ireq_addr never changes
  // until the ibus has answered; the stale answer is then dropped in DRAIN.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    seq_nx     = seq;
    pending_nx = pending_pc;
    latch      = 1'b0;
    if (bus.jw_do_jump) begin
      seq_nx = bus.jw_inst_counter + 1'b1;
      unique case (state)
        IDLE: begin
          pc_nx    = target;
          state_nx = FETCH;
        end
        FETCH: begin
          if (bus.iresp_valid) begin
            pc_nx = target;
          end else begin
            pending_nx = target;
            state_nx   = DRAIN;
          end
        end
        HOLD: begin
          pc_nx    = target;
          state_nx = FETCH;
        end
        DRAIN: begin
          pending_nx = target;
          if (bus.iresp_valid) begin
            pc_nx    = target;
            state_nx = FETCH;
          end
        end
      endcase
    end else begin
      unique case (state)
        IDLE: state_nx = FETCH;
        FETCH: begin
          if (bus.iresp_valid) begin
            latch    = 1'b1;
            pc_nx    = pc + 64'd4;
            seq_nx   = seq + 1'b1;
            state_nx = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) state_nx = FETCH;
        end
        DRAIN: begin
          if (bus.iresp_valid) begin
            pc_nx    = pending_pc;
            state_nx = FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      seq            <= '0;
      pending_pc     <= '0;
      out_pc_q       <= '0;
      out_inst_q     <= '0;
      out_counter_q  <= '0;
      misalign_q     <= 1'b0;
      jump_cnt_q     <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      seq        <= seq_nx;
      pending_pc <= pending_nx;
      if (latch) begin
        out_pc_q      <= pc;
        out_inst_q    <= bus.iresp_data;
        out_counter_q <= seq;
      end
      if (bus.jw_do_jump && (bus.jw_dest_addr[1:0] != 2'b00)) misalign_q <= 1'b1;
      if (bus.jw_jump_inst) jump_cnt_q <= jump_cnt_q + 1'b1;
      if (bus.jw_do_jump) redirect_cnt_q <= redirect_cnt_q + 1'b1;
    end
  end

endmodule
